// File: rtl/wb_arb_pkg.sv
// Shared types and helpers for the round-robin Wishbone arbiter.
// Holds the FSM state encoding, a clog2 helper and the flattened-bus slice helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_OWN   = 2'd1,
        ST_TERR  = 2'd2,
        ST_DRAIN = 2'd3
    } arb_state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        return r;
    endfunction

    // Low bit of master idx's slice in a flattened per-master bus.
    function automatic int slice_lo(input int idx, input int width);
        return idx * width;
    endfunction

endpackage

// File: rtl/wb_rr_picker.sv
// Combinational round-robin picker: searches ptr+1, ptr+2, ... mod N for the first request.
// Zero latency; no backpressure (pure function of req and ptr).
module wb_rr_picker #(
    parameter int N  = 2,
    parameter int PW = 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt,
    output logic          vld
);

    always_comb begin
        gnt = '0;
        vld = 1'b0;
        for (int k = 1; k <= N; k++) begin
            for (int j = 0; j < N; j++) begin
                if (!vld && req[j] && (((int'(ptr) + k) % N) == j)) begin
                    gnt[j] = 1'b1;
                    vld    = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone arbiter: one registered grant held for the whole CYC, watchdog abort.
// Grant 1 cycle after CYC; slave ACK/ERR reach the owner combinationally; a stalled owner is aborted.
module wb_rr_arbiter
    import wb_arb_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int BUS_ADDR_WIDTH = 8,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                                      wb_clk_i,
    input  logic                                      wb_rst_n_i,
    input  logic [NUM_MASTERS-1:0]                    m_cyc_i,
    input  logic [NUM_MASTERS-1:0]                    m_stb_i,
    input  logic [NUM_MASTERS-1:0]                    m_we_i,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH/8-1:0]   m_sel_i,
    input  logic [NUM_MASTERS*BUS_ADDR_WIDTH-1:0]     m_adr_i,
    input  logic [NUM_MASTERS*BUS_DATA_WIDTH-1:0]     m_dat_i,
    output logic [BUS_DATA_WIDTH-1:0]                 m_dat_o,
    output logic [NUM_MASTERS-1:0]                    m_ack_o,
    output logic [NUM_MASTERS-1:0]                    m_err_o,
    output logic                                      s_cyc_o,
    output logic                                      s_stb_o,
    output logic                                      s_we_o,
    output logic [BUS_DATA_WIDTH/8-1:0]               s_sel_o,
    output logic [BUS_ADDR_WIDTH-1:0]                 s_adr_o,
    output logic [BUS_DATA_WIDTH-1:0]                 s_dat_o,
    input  logic [BUS_DATA_WIDTH-1:0]                 s_dat_i,
    input  logic                                      s_ack_i,
    input  logic                                      s_err_i,
    output logic [NUM_MASTERS-1:0]                    gnt_o,
    output logic                                      timeout_o
);

    localparam int PW  = clog2(NUM_MASTERS);
    localparam int SW  = BUS_DATA_WIDTH / 8;
    localparam int CWR = clog2(TIMEOUT_CYCLES + 1);
    localparam int CW  = (CWR < 1) ? 1 : CWR;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [CW-1:0] WD_TERM = CW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    arb_state_t              state;
    logic [PW-1:0]           ptr;
    logic [CW-1:0]           wdog;
    logic [NUM_MASTERS-1:0]  pick_gnt;
    logic                    pick_vld;
    logic [PW-1:0]           owner;
    logic                    owner_cyc;
    logic                    owner_stb;
    logic                    own;
    logic                    stalled;

    wb_rr_picker #(.N(NUM_MASTERS), .PW(PW)) u_picker (
        .req (m_cyc_i),
        .ptr (ptr),
        .gnt (pick_gnt),
        .vld (pick_vld)
    );

    always_comb begin
        owner   = '0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        for (int j = 0; j < NUM_MASTERS; j++) begin
            if (gnt_o[j]) begin
                owner   = PW'(j);
                s_sel_o = s_sel_o | m_sel_i[slice_lo(j, SW) +: SW];
                s_adr_o = s_adr_o | m_adr_i[slice_lo(j, BUS_ADDR_WIDTH) +: BUS_ADDR_WIDTH];
                s_dat_o = s_dat_o | m_dat_i[slice_lo(j, BUS_DATA_WIDTH) +: BUS_DATA_WIDTH];
            end
        end
    end

    // Everything the slave and masters see derives from registered gnt/state, so reset
    // releases the bus asynchronously.
    assign owner_cyc = |(gnt_o & m_cyc_i);
    assign owner_stb = |(gnt_o & m_stb_i);
    assign own       = (state == ST_OWN);
    assign s_cyc_o   = own & owner_cyc;
    assign s_stb_o   = own & owner_cyc & owner_stb;
    assign s_we_o    = |(gnt_o & m_we_i);
    assign m_dat_o   = s_dat_i;
    assign m_ack_o   = own ? (gnt_o & {NUM_MASTERS{s_ack_i}}) : '0;
    assign m_err_o   = own ? (gnt_o & {NUM_MASTERS{s_err_i}})
                     : ((state == ST_TERR) ? gnt_o : '0);
    assign stalled   = s_stb_o & ~s_ack_i & ~s_err_i;

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            state     <= ST_IDLE;
            gnt_o     <= '0;
            ptr       <= PW'(NUM_MASTERS - 1);
            wdog      <= '0;
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wdog <= '0;
                    if (pick_vld) begin
                        gnt_o <= pick_gnt;
                        state <= ST_OWN;
                    end
                end
                ST_OWN: begin
                    if (!owner_cyc) begin
                        state <= ST_IDLE;
                        gnt_o <= '0;
                        ptr   <= owner;
                        wdog  <= '0;
                    end else if (WD_EN && stalled && (wdog == WD_TERM)) begin
                        state     <= ST_TERR;
                        timeout_o <= 1'b1;
                        wdog      <= '0;
                    end else if (WD_EN && stalled) begin
                        wdog <= wdog + 1'b1;
                    end else begin
                        wdog <= '0;
                    end
                end
                ST_TERR: state <= ST_DRAIN;
                ST_DRAIN: begin
                    if (!owner_cyc) begin
                        state <= ST_IDLE;
                        gnt_o <= '0;
                        ptr   <= owner;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_rr_arbiter.sv
// Directed bench for wb_rr_arbiter (2 masters, 32-bit data, 8-bit address, timeout 4).
module tb_wb_rr_arbiter;

    logic        clk;
    logic        rst_n;
    logic [1:0]  m_cyc, m_stb, m_we;
    logic [7:0]  m_sel;
    logic [15:0] m_adr;
    logic [63:0] m_dat;
    logic [31:0] m_dat_o;
    logic [1:0]  m_ack, m_err;
    logic        s_cyc, s_stb, s_we;
    logic [3:0]  s_sel;
    logic [7:0]  s_adr;
    logic [31:0] s_dat_o, s_dat_i;
    logic        s_ack, s_err;
    logic [1:0]  gnt;
    logic        timeout;

    int checks = 0;
    int errors = 0;

    wb_rr_arbiter #(
        .NUM_MASTERS(2), .BUS_DATA_WIDTH(32), .BUS_ADDR_WIDTH(8), .TIMEOUT_CYCLES(4)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_we_i(m_we), .m_sel_i(m_sel),
        .m_adr_i(m_adr), .m_dat_i(m_dat), .m_dat_o(m_dat_o),
        .m_ack_o(m_ack), .m_err_o(m_err),
        .s_cyc_o(s_cyc), .s_stb_o(s_stb), .s_we_o(s_we), .s_sel_o(s_sel),
        .s_adr_o(s_adr), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack), .s_err_i(s_err),
        .gnt_o(gnt), .timeout_o(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        m_sel = '0; m_adr = '0; m_dat = '0;
        s_dat_i = '0; s_ack = 1'b0; s_err = 1'b0;
        #3;
        checks++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0 || s_stb !== 1'b0 || timeout !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got gnt=%b cyc=%b stb=%b to=%b want 00 0 0 0", gnt, s_cyc, s_stb, timeout);
        end
        checks++;
        if (m_ack !== 2'b00 || m_err !== 2'b00) begin
            errors++;
            $display("FAIL reset_ack_err got ack=%b err=%b want 00 00", m_ack, m_err);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_single_write();
        @(negedge clk);
        m_cyc = 2'b01; m_stb = 2'b01; m_we = 2'b01;
        m_sel = 8'h3F; m_adr = 16'h5500; m_dat = 64'h12345678_DEADBEEF;
        #1;
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL single_latency got gnt=%b want 00", gnt);
        end
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b01 || s_cyc !== 1'b1 || s_stb !== 1'b1 || s_we !== 1'b1) begin
            errors++;
            $display("FAIL single_grant got gnt=%b cyc=%b stb=%b we=%b want 01 1 1 1", gnt, s_cyc, s_stb, s_we);
        end
        checks++;
        if (s_adr !== 8'h00 || s_dat_o !== 32'hDEADBEEF || s_sel !== 4'hF) begin
            errors++;
            $display("FAIL single_mux got adr=%h dat=%h sel=%h want 00 deadbeef f", s_adr, s_dat_o, s_sel);
        end
        checks++;
        if (m_ack !== 2'b01) begin
            errors++; $display("FAIL single_ack got %b want 01", m_ack);
        end
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b00; m_stb = 2'b00; m_we = 2'b00;
        #1;
        checks++;
        if (s_cyc !== 1'b0 || m_ack !== 2'b00) begin
            errors++; $display("FAIL single_drop got cyc=%b ack=%b want 0 00", s_cyc, m_ack);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL single_release got gnt=%b want 00", gnt);
        end
    endtask

    task automatic test_contention();
        do_reset();
        @(negedge clk);
        m_cyc = 2'b11;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL cont_first got gnt=%b want 01", gnt);
        end
        m_cyc = 2'b10;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL cont_dead1 got gnt=%b want 00", gnt);
        end
        m_cyc = 2'b11;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b10) begin
            errors++; $display("FAIL cont_second got gnt=%b want 10", gnt);
        end
        m_cyc = 2'b01;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL cont_dead2 got gnt=%b want 00", gnt);
        end
        m_cyc = 2'b11;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL cont_alternate got gnt=%b want 01", gnt);
        end
        m_cyc = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_block();
        m_cyc = 2'b10; m_stb = 2'b10; m_we = 2'b00; m_adr = 16'h4000;
        @(negedge clk);
        m_cyc = 2'b11; m_stb = 2'b11;
        for (int b = 0; b < 3; b++) begin
            if (b > 0) @(negedge clk);
            m_adr = {8'h40 + 8'(b), 8'h00};
            s_ack = 1'b1; s_dat_i = 32'hA000 + 32'(b);
            #1;
            checks++;
            if (gnt !== 2'b10 || s_adr !== 8'h40 + 8'(b)) begin
                errors++; $display("FAIL block_beat%0d got gnt=%b adr=%h want 10 %h", b, gnt, s_adr, 8'h40 + 8'(b));
            end
            checks++;
            if (m_ack !== 2'b10 || m_dat_o !== 32'hA000 + 32'(b)) begin
                errors++; $display("FAIL block_ack%0d got ack=%b dat=%h want 10 %h", b, m_ack, m_dat_o, 32'hA000 + 32'(b));
            end
        end
        @(negedge clk);
        s_ack = 1'b0; m_cyc = 2'b01; m_stb = 2'b01;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL block_dead got gnt=%b want 00", gnt);
        end
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL block_next got gnt=%b want 01", gnt);
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        m_cyc = 2'b01; m_stb = 2'b01;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (s_stb !== 1'b1 || timeout !== 1'b0 || m_err !== 2'b00) begin
                errors++; $display("FAIL to_wait%0d got stb=%b to=%b err=%b want 1 0 00", i, s_stb, timeout, m_err);
            end
        end
        @(negedge clk);
        checks++;
        if (timeout !== 1'b1 || m_err !== 2'b01 || s_cyc !== 1'b0 || s_stb !== 1'b0) begin
            errors++; $display("FAIL to_abort got to=%b err=%b cyc=%b stb=%b want 1 01 0 0", timeout, m_err, s_cyc, s_stb);
        end
        @(negedge clk);
        s_ack = 1'b1;
        #1;
        checks++;
        if (timeout !== 1'b0 || m_err !== 2'b00 || m_ack !== 2'b00 || s_cyc !== 1'b0 || gnt !== 2'b01) begin
            errors++; $display("FAIL to_drain got to=%b err=%b ack=%b cyc=%b gnt=%b want 0 00 00 0 01", timeout, m_err, m_ack, s_cyc, gnt);
        end
        @(negedge clk);
        s_ack = 1'b0;
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL to_hold got gnt=%b want 01", gnt);
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b00) begin
            errors++; $display("FAIL to_release got gnt=%b want 00", gnt);
        end
    endtask

    task automatic test_ack_terminal();
        m_cyc = 2'b01; m_stb = 2'b01;
        repeat (4) @(negedge clk);
        s_ack = 1'b1;
        #1;
        checks++;
        if (m_ack !== 2'b01) begin
            errors++; $display("FAIL term_ack got %b want 01", m_ack);
        end
        @(negedge clk);
        s_ack = 1'b0;
        checks++;
        if (timeout !== 1'b0 || m_err !== 2'b00 || gnt !== 2'b01 || s_cyc !== 1'b1) begin
            errors++; $display("FAIL term_no_to got to=%b err=%b gnt=%b cyc=%b want 0 00 01 1", timeout, m_err, gnt, s_cyc);
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        m_cyc = 2'b10; m_stb = 2'b10;
        @(negedge clk);
        s_err = 1'b1;
        #1;
        checks++;
        if (gnt !== 2'b10 || m_err !== 2'b10) begin
            errors++; $display("FAIL mid_err got gnt=%b err=%b want 10 10", gnt, m_err);
        end
        s_err = 1'b0;
        m_cyc = 2'b11; m_stb = 2'b11;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (gnt !== 2'b00 || s_cyc !== 1'b0 || m_ack !== 2'b00 || m_err !== 2'b00) begin
            errors++; $display("FAIL mid_async got gnt=%b cyc=%b ack=%b err=%b want 00 0 00 00", gnt, s_cyc, m_ack, m_err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (gnt !== 2'b01) begin
            errors++; $display("FAIL mid_first got gnt=%b want 01", gnt);
        end
        m_cyc = 2'b00; m_stb = 2'b00;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_contention();
        test_block();
        test_timeout();
        test_ack_terminal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
